reg32_hex_scroller: RTL and testbench



---
 rtl/reg_display_pkg.sv | 22 ++
 rtl/hex7seg_decoder.sv | 11 +
 rtl/reg32_hex_scroller.sv | 101 ++++++++++
 tb/tb_reg32_hex_scroller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reg_display_pkg.sv
// Shared types and constants for the 7-segment register display path.
// Segment patterns are active-low, bit6 = g .. bit0 = a.
package reg_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK   = 7'h7F;
    localparam int   NUM_DISPLAYS = 6;
    localparam int   DATA_DIGITS  = 8;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex7seg_decoder
    import reg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/reg32_hex_scroller.sv
// Scrolls a 32-bit word as 8 hex digits (plus a blank gap) across HEX5..HEX0.
// Any change of D restarts the scroll at the most significant nibble.
module reg32_hex_scroller
    import reg_display_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int GAP      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] D,
    input  logic        hold,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam int SEQ_LEN = DATA_DIGITS + GAP;
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int POS_W   = $clog2(SEQ_LEN);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SEQ_LEN - 1);

    logic [31:0]      shadow;
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] tick_cnt;
    logic             word_change;
    logic             tick_wrap;

    logic [NUM_DISPLAYS-1:0][6:0] seg_bus;

    assign word_change = (D != shadow);
    assign tick_wrap   = (tick_cnt == TICK_LAST);

    // A word change wins over both hold and a coincident tick wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow   <= '0;
            pos      <= '0;
            tick_cnt <= '0;
        end else if (word_change) begin
            shadow   <= D;
            pos      <= '0;
            tick_cnt <= '0;
        end else if (!hold) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                pos      <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_DISPLAYS; k++) begin : g_digit
        logic [4:0] raw_idx;
        logic [4:0] seq_idx;
        logic [2:0] nib_sel;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] dec_seg;
        logic [6:0] seg_q;

        // Display k shows sequence entry (pos + 5 - k) mod SEQ_LEN; one
        // subtraction suffices because the raw index stays below 2*SEQ_LEN.
        always_comb begin
            raw_idx = 5'(pos) + 5'(NUM_DISPLAYS - 1 - k);
            seq_idx = (raw_idx >= 5'(SEQ_LEN)) ? raw_idx - 5'(SEQ_LEN) : raw_idx;
            blank   = (seq_idx >= 5'(DATA_DIGITS));
            nib_sel = 3'd7 - seq_idx[2:0];
            nib     = shadow[{nib_sel, 2'b00} +: 4];
        end

        hex7seg_decoder u_dec (
            .nibble (nib),
            .seg    (dec_seg)
        );

        always_ff @(posedge clock) begin
            if (reset) begin
                seg_q <= SEG_BLANK;
            end else begin
                seg_q <= blank ? SEG_BLANK : dec_seg;
            end
        end

        assign seg_bus[k] = seg_q;
    end

    assign HEX0 = seg_bus[0];
    assign HEX1 = seg_bus[1];
    assign HEX2 = seg_bus[2];
    assign HEX3 = seg_bus[3];
    assign HEX4 = seg_bus[4];
    assign HEX5 = seg_bus[5];

endmodule

// File: tb/tb_reg32_hex_scroller.sv
// Scoreboard bench: expected HEX5..HEX0 patterns are queued against a cycle
// number and a negedge monitor compares whatever is due on that cycle.
module tb_reg32_hex_scroller;

    localparam int BL = 16;
    localparam logic [6:0] TB_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int          cyc;
        int          dut;
        logic [41:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [41:0] mon_act;

    logic        a_reset, a_hold;
    logic [31:0] a_d;
    logic [6:0]  a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0;
    logic        b_reset, b_hold;
    logic [31:0] b_d;
    logic [6:0]  b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0;

    reg32_hex_scroller #(.TICK_DIV(4), .GAP(2)) dut_a (
        .clock (clk), .reset (a_reset), .D (a_d), .hold (a_hold),
        .HEX5 (a_hex5), .HEX4 (a_hex4), .HEX3 (a_hex3),
        .HEX2 (a_hex2), .HEX1 (a_hex1), .HEX0 (a_hex0)
    );

    reg32_hex_scroller #(.TICK_DIV(1), .GAP(0)) dut_b (
        .clock (clk), .reset (b_reset), .D (b_d), .hold (b_hold),
        .HEX5 (b_hex5), .HEX4 (b_hex4), .HEX3 (b_hex3),
        .HEX2 (b_hex2), .HEX1 (b_hex1), .HEX0 (b_hex0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [41:0] ex6(input int d5, input int d4, input int d3,
                                        input int d2, input int d1, input int d0);
        int          d[6];
        logic [41:0] r;
        d = '{d0, d1, d2, d3, d4, d5};
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*7 +: 7] = (d[i] == BL) ? 7'h7F : TB_SEG[d[i][3:0]];
        end
        return r;
    endfunction

    task automatic expect_hex(input int c, input int dut, input logic [41:0] e, input string nm);
        exp_t x;
        x.cyc  = c;
        x.dut  = dut;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    mon_act = (sb[i].dut == 0)
                        ? {a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}
                        : {b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};
                    n_cmp++;
                    if (mon_act !== sb[i].exp) begin
                        n_bad++;
                        $display("FAIL %s @cyc %0d: got %h, required %h",
                                 sb[i].name, cyc, mon_act, sb[i].exp);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: not sampled at cyc %0d, now %0d, required %h",
                             sb[i].name, sb[i].cyc, cyc, sb[i].exp);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cyc %0d, required finish by cyc 150", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; a_hold = 1'b0; a_d = 32'h0;
        b_reset = 1'b1; b_hold = 1'b0; b_d = 32'h12345678;

        // DUT A: TICK_DIV=4, GAP=2, sequence length 10
        expect_hex(3,   0, ex6(BL,BL,BL,BL,BL,BL),   "a_reset_blank");
        expect_hex(4,   0, ex6(0,0,0,0,0,0),         "a_release_zeros");
        expect_hex(6,   0, ex6(1,2,3,4,5,6),         "a_load_pos0");
        expect_hex(10,  0, ex6(2,3,4,5,6,7),         "a_pos1");
        expect_hex(14,  0, ex6(3,4,5,6,7,8),         "a_pos2");
        expect_hex(30,  0, ex6(7,8,BL,BL,1,2),       "a_pos6_gap");
        expect_hex(38,  0, ex6(BL,BL,1,2,3,4),       "a_pos8");
        expect_hex(42,  0, ex6(BL,1,2,3,4,5),        "a_pos9");
        expect_hex(46,  0, ex6(1,2,3,4,5,6),         "a_wrap_pos0");
        expect_hex(58,  0, ex6(4,5,6,7,8,BL),        "a_pos3_before_change");
        expect_hex(59,  0, ex6(4,5,6,7,8,BL),        "a_change_capture_cycle");
        expect_hex(60,  0, ex6('hA,'hB,'hC,'hD,'hE,'hF), "a_restart_midscroll");
        expect_hex(64,  0, ex6('hB,'hC,'hD,'hE,'hF,0),   "a_abcd_pos1");
        expect_hex(67,  0, ex6('hB,'hC,'hD,'hE,'hF,0),   "a_before_wrap_change");
        expect_hex(68,  0, ex6('hF,'hE,'hD,'hC,'hB,'hA), "a_change_on_wrap_pos0");
        expect_hex(71,  0, ex6('hF,'hE,'hD,'hC,'hB,'hA), "a_tick_cleared_on_change");
        expect_hex(72,  0, ex6('hE,'hD,'hC,'hB,'hA,9),   "a_fedc_pos1");
        expect_hex(80,  0, ex6('hD,'hC,'hB,'hA,9,8),     "a_hold_early");
        expect_hex(96,  0, ex6('hD,'hC,'hB,'hA,9,8),     "a_hold_late");
        expect_hex(99,  0, ex6('hD,'hC,'hB,'hA,9,8),     "a_resume_partial");
        expect_hex(100, 0, ex6('hC,'hB,'hA,9,8,BL),      "a_resume_advance");
        expect_hex(103, 0, ex6('hC,'hB,'hA,9,8,BL),      "a_hold_before_change");
        expect_hex(104, 0, ex6(0,0,0,0,0,0),             "a_change_under_hold");
        expect_hex(115, 0, ex6(0,0,0,0,0,0),             "a_held_after_change");
        expect_hex(127, 0, ex6(0,0,0,0,0,0),             "a_release_pos2");
        expect_hex(128, 0, ex6(0,0,0,0,0,BL),            "a_release_pos3");

        // DUT B: TICK_DIV=1, GAP=0, sequence length 8
        expect_hex(130, 1, ex6(BL,BL,BL,BL,BL,BL), "b_reset_blank");
        expect_hex(131, 1, ex6(0,0,0,0,0,0),       "b_release_zeros");
        expect_hex(132, 1, ex6(1,2,3,4,5,6),       "b_pos0");
        expect_hex(133, 1, ex6(2,3,4,5,6,7),       "b_pos1");
        expect_hex(135, 1, ex6(4,5,6,7,8,1),       "b_pos3_nogap");
        expect_hex(138, 1, ex6(7,8,1,2,3,4),       "b_pos6_nogap");
        expect_hex(140, 1, ex6(1,2,3,4,5,6),       "b_wrap_mod8");
        expect_hex(142, 1, ex6(BL,BL,BL,BL,BL,BL), "b_midscroll_reset");
        expect_hex(143, 1, ex6(0,0,0,0,0,0),       "b_after_reset_zeros");
        expect_hex(144, 1, ex6(1,2,3,4,5,6),       "b_after_reset_reload");
        expect_hex(145, 1, ex6(2,3,4,5,6,7),       "b_after_reset_pos1");

        wait_until(3);   a_reset = 1'b0;
        wait_until(4);   a_d = 32'h12345678;
        wait_until(58);  a_d = 32'hABCDEF01;
        wait_until(66);  a_d = 32'hFEDCBA98;
        wait_until(76);  a_hold = 1'b1;
        wait_until(96);  a_hold = 1'b0;
        wait_until(100); a_hold = 1'b1;
        wait_until(102); a_d = 32'h0;
        wait_until(115); a_hold = 1'b0;

        wait_until(130); b_reset = 1'b0;
        wait_until(141); b_reset = 1'b1;
        wait_until(142); b_reset = 1'b0;

        wait_until(150);
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never sampled (due cyc %0d), required %h",
                     sb[0].name, sb[0].cyc, sb[0].exp);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
